// File: rtl/mod_arith_seq.sv
// Sequencer for one modular-arithmetic op: load B, start the core, wait under a watchdog, clear B, report.
// Min latency from accept to done is 5 cycles; illegal ops report in 1. Busy (cmd_ready=0) outside IDLE.
module mod_arith_seq #(
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic       cmd_mod,
  output logic [2:0] b_op,
  output logic       b_en,
  output logic       flg_mod,
  output logic       core_mode,
  output logic       core_start,
  input  logic       core_done,
  output logic       core_abort,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOADB, S_START, S_WAIT, S_CLEAR, S_DONE
  } state_t;

  localparam logic [2:0] B_SETY    = 3'b000;
  localparam logic [2:0] B_SETA    = 3'b001;
  localparam logic [2:0] B_DIVINIT = 3'b100;
  localparam logic [2:0] B_MONT    = 3'b101;
  localparam logic [2:0] B_MONTINV = 3'b110;
  localparam logic [2:0] B_CLEAR   = 3'b111;
  localparam logic [9:0] LIMIT     = 10'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_op;
  logic       r_mod;
  logic       r_mode;
  logic       r_err;
  logic       r_abort;
  logic [9:0] r_cnt;
  logic [2:0] w_load_op;
  logic       w_accept;
  logic       w_legal;
  logic       w_expire;

  assign w_accept = cmd_valid && (r_state == S_IDLE);
  assign w_legal  = (cmd_op <= 3'd4);
  // Completion has priority over the watchdog when both land in the same cycle.
  assign w_expire = (r_cnt == LIMIT) && !core_done;

  always_comb begin
    w_load_op = B_CLEAR;
    case (r_op)
      3'd0:    w_load_op = B_SETY;
      3'd1:    w_load_op = B_SETA;
      3'd2:    w_load_op = B_MONT;
      3'd3:    w_load_op = B_MONTINV;
      3'd4:    w_load_op = B_DIVINIT;
      default: w_load_op = B_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    b_en       = 1'b0;
    b_op       = B_CLEAR;
    core_start = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (w_accept) w_next = w_legal ? S_LOADB : S_DONE;
      end
      S_LOADB: begin
        b_en   = 1'b1;
        b_op   = w_load_op;
        w_next = S_START;
      end
      S_START: begin
        core_start = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        if (core_done || w_expire) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        b_en   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= 3'd0;
      r_mod   <= 1'b0;
      r_mode  <= 1'b0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
      r_cnt   <= 10'd0;
    end else begin
      r_abort <= (r_state == S_WAIT) && w_expire;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_mod  <= cmd_mod;
        r_mode <= (cmd_op == 3'd4);
        r_err  <= !w_legal;
      end
      if (r_state == S_START) begin
        r_cnt <= 10'd0;
      end else if (r_state == S_WAIT) begin
        if (core_done)     r_err <= 1'b0;
        else if (w_expire) r_err <= 1'b1;
        else               r_cnt <= r_cnt + 10'd1;
      end
    end
  end

  assign flg_mod    = r_mod;
  assign core_mode  = r_mode;
  assign core_abort = r_abort && (r_state == S_CLEAR);
  assign err        = r_err;

endmodule

// File: tb/tb_mod_arith_seq.sv
// Directed bench for mod_arith_seq: default-TIMEOUT instance plus a TIMEOUT=4 instance for watchdog cases.
module tb_mod_arith_seq;

  logic       clk;
  logic       rst;
  logic       cmd_valid, cmd_mod, core_done;
  logic [2:0] cmd_op;
  logic       cmd_ready, b_en, flg_mod, core_mode, core_start, core_abort, done, err;
  logic [2:0] b_op;
  logic       cmd_valid4, cmd_mod4, core_done4;
  logic [2:0] cmd_op4;
  logic       cmd_ready4, b_en4, flg_mod4, core_mode4, core_start4, core_abort4, done4, err4;
  logic [2:0] b_op4;
  logic [10:0] obs, obs4;
  int checks;
  int errors;

  mod_arith_seq u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mod(cmd_mod), .b_op(b_op), .b_en(b_en),
    .flg_mod(flg_mod), .core_mode(core_mode), .core_start(core_start),
    .core_done(core_done), .core_abort(core_abort), .done(done), .err(err)
  );

  mod_arith_seq #(.TIMEOUT(4)) u_dut4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op4), .cmd_mod(cmd_mod4), .b_op(b_op4), .b_en(b_en4),
    .flg_mod(flg_mod4), .core_mode(core_mode4), .core_start(core_start4),
    .core_done(core_done4), .core_abort(core_abort4), .done(done4), .err(err4)
  );

  // {cmd_ready, b_en, b_op, flg_mod, core_mode, core_start, core_abort, done, err}
  assign obs  = {cmd_ready, b_en, b_op, flg_mod, core_mode, core_start, core_abort, done, err};
  assign obs4 = {cmd_ready4, b_en4, b_op4, flg_mod4, core_mode4, core_start4, core_abort4, done4, err4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    if (obs !== 11'b1_0_111_0_0_0_0_0_0) begin
      errors++; $display("FAIL reset_hold obs=%b exp=%b", obs, 11'b1_0_111_0_0_0_0_0_0);
    end
    checks++;
    rst = 1'b0;
    tick();
    if (obs !== 11'b1_0_111_0_0_0_0_0_0) begin
      errors++; $display("FAIL reset_idle obs=%b exp=%b", obs, 11'b1_0_111_0_0_0_0_0_0);
    end
    checks++;
    if (obs4 !== 11'b1_0_111_0_0_0_0_0_0) begin
      errors++; $display("FAIL reset_idle4 obs=%b exp=%b", obs4, 11'b1_0_111_0_0_0_0_0_0);
    end
    checks++;
  endtask

  task automatic test_mul_y;
    logic [10:0] e;
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) tick();
      case (i)
        0: e = 11'b1_0_111_0_0_0_0_0_0;
        1: e = 11'b0_1_000_0_0_0_0_0_0;
        2: e = 11'b0_0_111_0_0_1_0_0_0;
        3: e = 11'b0_0_111_0_0_0_0_0_0;
        4: e = 11'b0_1_111_0_0_0_0_0_0;
        5: e = 11'b0_0_111_0_0_0_0_1_0;
        default: e = 11'b1_0_111_0_0_0_0_0_0;
      endcase
      if (obs !== e) begin
        errors++; $display("FAIL mul_y_c%0d obs=%b exp=%b", i, obs, e);
      end
      checks++;
      cmd_valid = (i == 0);
      cmd_op    = 3'd0;
      cmd_mod   = 1'b0;
      core_done = (i == 3);
    end
  endtask

  task automatic test_div;
    logic [10:0] e;
    for (int i = 0; i <= 15; i++) begin
      if (i > 0) tick();
      case (i)
        0:  e = 11'b1_0_111_0_0_0_0_0_0;
        1:  e = 11'b0_1_100_1_1_0_0_0_0;
        2:  e = 11'b0_0_111_1_1_1_0_0_0;
        13: e = 11'b0_1_111_1_1_0_0_0_0;
        14: e = 11'b0_0_111_1_1_0_0_1_0;
        15: e = 11'b1_0_111_1_1_0_0_0_0;
        default: e = 11'b0_0_111_1_1_0_0_0_0;
      endcase
      if (obs !== e) begin
        errors++; $display("FAIL div_c%0d obs=%b exp=%b", i, obs, e);
      end
      checks++;
      cmd_valid = (i == 0);
      cmd_op    = 3'd4;
      cmd_mod   = 1'b1;
      core_done = (i == 12);
    end
  endtask

  task automatic test_illegal;
    logic [10:0] e;
    for (int i = 0; i <= 2; i++) begin
      if (i > 0) tick();
      case (i)
        0: e = 11'b1_0_111_1_1_0_0_0_0;
        1: e = 11'b0_0_111_0_0_0_0_1_1;
        default: e = 11'b1_0_111_0_0_0_0_0_1;
      endcase
      if (obs !== e) begin
        errors++; $display("FAIL illegal_c%0d obs=%b exp=%b", i, obs, e);
      end
      checks++;
      cmd_valid = (i == 0);
      cmd_op    = 3'd6;
      cmd_mod   = 1'b0;
    end
  endtask

  task automatic test_timeout;
    logic [10:0] e;
    for (int i = 0; i <= 9; i++) begin
      if (i > 0) tick();
      case (i)
        0: e = 11'b1_0_111_0_0_0_0_0_0;
        1: e = 11'b0_1_101_0_0_0_0_0_0;
        2: e = 11'b0_0_111_0_0_1_0_0_0;
        7: e = 11'b0_1_111_0_0_0_1_0_1;
        8: e = 11'b0_0_111_0_0_0_0_1_1;
        9: e = 11'b1_0_111_0_0_0_0_0_1;
        default: e = 11'b0_0_111_0_0_0_0_0_0;
      endcase
      if (obs4 !== e) begin
        errors++; $display("FAIL timeout_c%0d obs=%b exp=%b", i, obs4, e);
      end
      checks++;
      cmd_valid4 = (i == 0);
      cmd_op4    = 3'd2;
      cmd_mod4   = 1'b0;
      core_done4 = 1'b0;
    end
  endtask

  task automatic test_done_at_limit;
    logic [10:0] e;
    for (int i = 0; i <= 9; i++) begin
      if (i > 0) tick();
      case (i)
        0: e = 11'b1_0_111_0_0_0_0_0_1;
        1: e = 11'b0_1_000_0_0_0_0_0_0;
        2: e = 11'b0_0_111_0_0_1_0_0_0;
        7: e = 11'b0_1_111_0_0_0_0_0_0;
        8: e = 11'b0_0_111_0_0_0_0_1_0;
        9: e = 11'b1_0_111_0_0_0_0_0_0;
        default: e = 11'b0_0_111_0_0_0_0_0_0;
      endcase
      if (obs4 !== e) begin
        errors++; $display("FAIL limit_c%0d obs=%b exp=%b", i, obs4, e);
      end
      checks++;
      cmd_valid4 = (i == 0);
      cmd_op4    = 3'd0;
      cmd_mod4   = 1'b0;
      core_done4 = (i == 6);
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] e;
    for (int i = 0; i <= 11; i++) begin
      if (i > 0) tick();
      case (i)
        0:  e = 11'b1_0_111_0_0_0_0_0_1;
        1:  e = 11'b0_1_110_1_0_0_0_0_0;
        2:  e = 11'b0_0_111_1_0_1_0_0_0;
        3:  e = 11'b0_0_111_1_0_0_0_0_0;
        4:  e = 11'b0_0_111_1_0_0_0_0_0;
        5:  e = 11'b1_0_111_0_0_0_0_0_0;
        6:  e = 11'b0_1_001_0_0_0_0_0_0;
        7:  e = 11'b0_0_111_0_0_1_0_0_0;
        8:  e = 11'b0_0_111_0_0_0_0_0_0;
        9:  e = 11'b0_1_111_0_0_0_0_0_0;
        10: e = 11'b0_0_111_0_0_0_0_1_0;
        default: e = 11'b1_0_111_0_0_0_0_0_0;
      endcase
      if (obs !== e) begin
        errors++; $display("FAIL rst_mid_c%0d obs=%b exp=%b", i, obs, e);
      end
      checks++;
      rst       = (i == 4);
      cmd_valid = (i == 0) || (i == 5);
      cmd_op    = (i < 5) ? 3'd3 : 3'd1;
      cmd_mod   = (i < 5);
      core_done = (i == 8);
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] e;
    for (int i = 0; i <= 13; i++) begin
      if (i > 0) tick();
      case (i)
        0, 7, 13: e = 11'b1_0_111_0_0_0_0_0_0;
        1, 8:     e = 11'b0_1_000_0_0_0_0_0_0;
        2, 9:     e = 11'b0_0_111_0_0_1_0_0_0;
        5, 11:    e = 11'b0_1_111_0_0_0_0_0_0;
        6, 12:    e = 11'b0_0_111_0_0_0_0_1_0;
        default:  e = 11'b0_0_111_0_0_0_0_0_0;
      endcase
      if (obs !== e) begin
        errors++; $display("FAIL b2b_c%0d obs=%b exp=%b", i, obs, e);
      end
      checks++;
      cmd_valid = (i < 8);
      cmd_op    = 3'd0;
      cmd_mod   = 1'b0;
      core_done = (i == 1) || (i == 2) || (i == 4) || (i == 10);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_mod = 1'b0; core_done = 1'b0;
    cmd_valid4 = 1'b0; cmd_op4 = 3'd0; cmd_mod4 = 1'b0; core_done4 = 1'b0;
    test_reset();
    test_mul_y();
    test_div();
    test_illegal();
    test_timeout();
    test_done_at_limit();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
